lsq_buffer: RTL

- Registered load/store queue storage that sits directly upstream of the memory stage. It allocates entries in program order at dispatch and presents the whole array plus its tail to the memory stage.
- It absorbs the 1-indexed entry write-back the memory stage produces, and marks entries committed.
- It drains committed entries from the head; committed stores are written to the data cache through a busy handshake.

---
 rtl/lsq_buffer_pkg.sv | 41 ++++
 rtl/lsq_store_drain.sv | 81 ++++++++
 rtl/lsq_buffer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lsq_buffer_pkg.sv
// Shared load/store queue types, also consumed by the memory stage.
// The queue depth macro is guarded so a project-wide definition takes priority.
`ifndef LSQ_SIZE
`define LSQ_SIZE 8
`endif

package lsq_buffer_pkg;

    localparam int COLOR_W = 32;

    typedef logic [31:0] Address;
    typedef logic [31:0] MemoryWord;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_category_type;

    typedef enum logic [1:0] {
        DRAIN_IDLE  = 2'd0,
        DRAIN_ISSUE = 2'd1,
        DRAIN_WAIT  = 2'd2
    } drain_state_t;

    typedef struct packed {
        logic                valid;
        logic [31:0]         tag;
        Address              address;
        MemoryWord           value;
        logic [COLOR_W-1:0]  color;
        memory_category_type category;
        logic                ready;
        logic                committed;
    } lsq_entry;

    // Ring-index increment; size must be a power of two.
    function automatic logic [31:0] ring_inc(input logic [31:0] idx, input int size);
        return (idx + 32'd1) & 32'(size - 1);
    endfunction

endpackage

// File: rtl/lsq_store_drain.sv
// Head-of-queue drain: pops committed loads directly and runs committed
// stores through a one-cycle write request followed by a busy wait.
module lsq_store_drain
    import lsq_buffer_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  lsq_entry  i_head,
    input  logic      i_data_busy,
    output logic      o_pop,
    output logic      o_mem_write,
    output Address    o_store_address,
    output MemoryWord o_store_data
);

    drain_state_t r_state;
    logic         r_mem_write;
    Address       r_store_address;
    MemoryWord    r_store_data;
    logic         w_load_ready;
    logic         w_store_ready;
    logic         w_unused_head;

    assign w_load_ready  = i_head.valid && i_head.committed && (i_head.category == LOAD);
    assign w_store_ready = i_head.valid && i_head.committed && (i_head.category == STORE);
    assign w_unused_head = ^{i_head.tag, i_head.color, i_head.ready};

    // Pop strobe: loads leave from IDLE, stores leave once the cache is no longer busy.
    always_comb begin
        o_pop = 1'b0;
        case (r_state)
            DRAIN_IDLE: o_pop = w_load_ready;
            DRAIN_WAIT: o_pop = !i_data_busy;
            default:    o_pop = 1'b0;
        endcase
    end

    // Drain FSM with registered cache-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= DRAIN_IDLE;
            r_mem_write     <= 1'b0;
            r_store_address <= 32'd0;
            r_store_data    <= 32'd0;
        end else begin
            case (r_state)
                DRAIN_IDLE: begin
                    if (w_store_ready) begin
                        r_state         <= DRAIN_ISSUE;
                        r_mem_write     <= 1'b1;
                        r_store_address <= i_head.address;
                        r_store_data    <= i_head.value;
                    end else begin
                        r_mem_write     <= 1'b0;
                    end
                end
                DRAIN_ISSUE: begin
                    r_state     <= DRAIN_WAIT;
                    r_mem_write <= 1'b0;
                end
                DRAIN_WAIT: begin
                    r_mem_write <= 1'b0;
                    if (!i_data_busy) begin
                        r_state <= DRAIN_IDLE;
                    end else begin
                        r_state <= DRAIN_WAIT;
                    end
                end
                default: begin
                    r_state     <= DRAIN_IDLE;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_write     = r_mem_write;
    assign o_store_address = r_store_address;
    assign o_store_data    = r_store_data;

endmodule

// File: rtl/lsq_buffer.sv
// Registered load/store queue: in-order allocation, memory-stage write-back,
// commit marking, flush of speculative entries, and head drain to the cache.
module lsq_buffer
    import lsq_buffer_pkg::*;
#(
    parameter int LSQ_SIZE = `LSQ_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alloc_valid,
    input  logic [31:0]         alloc_tag,
    input  memory_category_type alloc_category,
    output logic                alloc_ready,
    input  logic [31:0]         upd_pointer,
    input  lsq_entry            upd_entry,
    input  logic                commit_valid,
    input  logic [31:0]         commit_tag,
    input  logic                flush,
    output lsq_entry            lsq [LSQ_SIZE],
    output logic [31:0]         lsq_tail,
    output logic [31:0]         lsq_head,
    output logic [31:0]         lsq_count,
    output logic                mem_write,
    output Address              store_address,
    output MemoryWord           store_data,
    input  logic                data_busy
);

    localparam int          IDX_W    = $clog2(LSQ_SIZE);
    localparam logic [31:0] IDX_MASK = 32'(LSQ_SIZE - 1);
    localparam logic [31:0] SIZE32   = 32'(LSQ_SIZE);

    lsq_entry           r_lsq [LSQ_SIZE];
    logic [31:0]        r_head;
    logic [31:0]        r_tail;
    logic [31:0]        r_count;
    logic [COLOR_W-1:0] r_color;

    lsq_entry           w_lsq [LSQ_SIZE];
    logic [31:0]        w_head;
    logic [31:0]        w_tail;
    logic [31:0]        w_count;
    logic [COLOR_W-1:0] w_color;
    logic [31:0]        w_ncommit;
    logic [31:0]        w_upd_idx;
    logic               w_alloc;
    logic               w_pop;
    lsq_entry           w_head_entry;
    logic               w_unused_upd;

    assign alloc_ready  = (r_count < SIZE32) && !flush;
    assign w_alloc      = alloc_valid && alloc_ready;
    assign w_upd_idx    = upd_pointer - 32'd1;
    assign w_head_entry = r_lsq[r_head[IDX_W-1:0]];
    assign w_unused_upd = ^{upd_entry.valid, upd_entry.tag, upd_entry.color,
                            upd_entry.category, upd_entry.committed, w_upd_idx[31:IDX_W]};

    lsq_store_drain u_drain (
        .clk             (clk),
        .reset           (reset),
        .i_head          (w_head_entry),
        .i_data_busy     (data_busy),
        .o_pop           (w_pop),
        .o_mem_write     (mem_write),
        .o_store_address (store_address),
        .o_store_data    (store_data)
    );

    // Next-state queue: commit, then update, then pop, then flush or allocate.
    always_comb begin
        w_lsq     = r_lsq;
        w_head    = r_head;
        w_tail    = r_tail;
        w_count   = r_count;
        w_color   = r_color;
        w_ncommit = 32'd0;

        for (int i = 0; i < LSQ_SIZE; i++) begin
            if (commit_valid && r_lsq[i].valid && (r_lsq[i].tag == commit_tag)) begin
                w_lsq[i].committed = 1'b1;
            end else begin
                w_lsq[i].committed = r_lsq[i].committed;
            end
        end

        if (!flush && (upd_pointer != 32'd0) && (upd_pointer <= SIZE32)
                && r_lsq[w_upd_idx[IDX_W-1:0]].valid) begin
            w_lsq[w_upd_idx[IDX_W-1:0]].address = upd_entry.address;
            w_lsq[w_upd_idx[IDX_W-1:0]].value   = upd_entry.value;
            w_lsq[w_upd_idx[IDX_W-1:0]].ready   = upd_entry.ready;
        end else begin
            w_ncommit = 32'd0;
        end

        if (w_pop) begin
            w_lsq[r_head[IDX_W-1:0]].valid = 1'b0;
            w_head = ring_inc(r_head, LSQ_SIZE);
        end else begin
            w_head = r_head;
        end

        // Surviving entries are all committed and contiguous from the new head.
        if (flush) begin
            for (int i = 0; i < LSQ_SIZE; i++) begin
                if (!w_lsq[i].committed) begin
                    w_lsq[i].valid = 1'b0;
                end else begin
                    w_lsq[i].valid = w_lsq[i].valid;
                end
                w_ncommit = w_ncommit + {31'd0, w_lsq[i].valid};
            end
            w_tail  = (w_head + w_ncommit) & IDX_MASK;
            w_count = w_ncommit;
        end else begin
            if (w_alloc) begin
                w_lsq[r_tail[IDX_W-1:0]] = '{valid: 1'b1, tag: alloc_tag, address: 32'd0,
                                             value: 32'd0, color: r_color,
                                             category: alloc_category, ready: 1'b0,
                                             committed: 1'b0};
                w_tail  = ring_inc(r_tail, LSQ_SIZE);
                w_color = r_color + {{(COLOR_W-1){1'b0}}, 1'b1};
            end else begin
                w_tail  = r_tail;
            end
            w_count = r_count + {31'd0, w_alloc} - {31'd0, w_pop};
        end

        if ((w_count == 32'd0) && !(w_alloc && !flush)) begin
            w_color = '0;
        end else begin
            w_color = w_color;
        end
    end

    // Queue state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LSQ_SIZE; i++) begin
                r_lsq[i] <= '0;
            end
            r_head  <= 32'd0;
            r_tail  <= 32'd0;
            r_count <= 32'd0;
            r_color <= '0;
        end else begin
            r_lsq   <= w_lsq;
            r_head  <= w_head;
            r_tail  <= w_tail;
            r_count <= w_count;
            r_color <= w_color;
        end
    end

    assign lsq       = r_lsq;
    assign lsq_head  = r_head;
    assign lsq_tail  = r_tail;
    assign lsq_count = r_count;

endmodule
